lvds_rx_deserializer: RTL

Receive-side counterpart of the LVDS display transmitter: recovers 7:1 FPD-Link serial streams (one clock lane, four data lanes) back into parallel RGB pixels with sync/enable. It sits after the differential input buffers and feeds pixel-domain logic or a loopback checker. A word-alignment state machine locks on the clock lane's `1100011` pattern. Every seventh bit-clock cycle it presents one decoded 24-bit pixel with a single-cycle valid strobe.

---
 rtl/lvds_rx_deserializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lvds_rx_deserializer.sv
// 7:1 FPD-Link receiver: aligns to the clock-lane word boundary and decodes
// the four data lanes into one RGB pixel with sync/enable per word.
module lvds_rx_deserializer #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ck_ser,
    input  logic [3:0] rx_ser,
    output logic       pixel_valid,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       locked,
    output logic       align_err
);

    localparam logic [6:0] CK_PATTERN = 7'b1100011;
    localparam logic [2:0] PHASE_LAST = 3'd6;
    localparam int         GW         = $clog2(LOCK_COUNT + 1);
    localparam int         MW         = $clog2(UNLOCK_COUNT + 1);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_COUNT);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [MW-1:0] MISS_MAX  = MW'(UNLOCK_COUNT);
    localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    phase;
    logic [2:0]    phase_nxt;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_nxt;
    logic [MW-1:0] miss_cnt;
    logic [MW-1:0] miss_nxt;
    logic          emit;
    logic          lose;
    logic          boundary;
    logic          ck_match;
    logic [6:0]    ck_sr;
    logic [6:0]    lane_sr [4];

    assign boundary = (phase == PHASE_LAST);
    assign ck_match = (ck_sr == CK_PATTERN);
    assign locked   = (state == LOCKED);

    // NOTE: every register uses <= so all flops sample pre-edge values together.
    // NOTE: the shift registers are plain flops, not a RAM, so they take reset too.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ck_sr <= '0;
            for (int i = 0; i < 4; i++) lane_sr[i] <= '0;
        end else begin
            ck_sr <= {ck_sr[5:0], ck_ser};
            for (int i = 0; i < 4; i++) lane_sr[i] <= {lane_sr[i][5:0], rx_ser[i]};
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned.
    always_comb begin
        state_nxt = state;
        phase_nxt = boundary ? 3'd0 : phase + 3'd1;
        good_nxt  = good_cnt;
        miss_nxt  = miss_cnt;
        emit      = 1'b0;
        lose      = 1'b0;
        case (state)
            HUNT: begin
                // Free-running search: any cycle may be the word boundary.
                phase_nxt = '0;
                if (ck_match) begin
                    good_nxt  = GW'(1);
                    miss_nxt  = '0;
                    state_nxt = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (ck_match) begin
                        if (good_cnt != GOOD_MAX) good_nxt = good_cnt + 1'b1;
                        if (good_cnt == GOOD_LAST) begin
                            state_nxt = LOCKED;
                            miss_nxt  = '0;
                        end
                    end else begin
                        state_nxt = HUNT;
                        good_nxt  = '0;
                        miss_nxt  = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (ck_match) begin
                        emit     = 1'b1;
                        miss_nxt = '0;
                    end else if (miss_cnt == MISS_LAST) begin
                        state_nxt = HUNT;
                        lose      = 1'b1;
                        good_nxt  = '0;
                        miss_nxt  = '0;
                    end else if (miss_cnt != MISS_MAX) begin
                        miss_nxt = miss_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            phase    <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            good_cnt <= good_nxt;
            miss_cnt <= miss_nxt;
        end
    end

    // Lane words are first-received-bit MSB; lane3 bit 6 carries no data.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pixel_valid <= 1'b0;
            align_err   <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
        end else begin
            pixel_valid <= emit;
            align_err   <= lose;
            if (emit) begin
                red   <= {lane_sr[3][1:0], lane_sr[0][5:0]};
                green <= {lane_sr[3][3:2], lane_sr[1][4:0], lane_sr[0][6]};
                blue  <= {lane_sr[3][5:4], lane_sr[2][3:0], lane_sr[1][6:5]};
                hsync <= lane_sr[2][4];
                vsync <= lane_sr[2][5];
                de    <= lane_sr[2][6];
            end
        end
    end

endmodule
